// File: rtl/cdc_sync_debounce.sv
// cdc_sync_debounce
//   Multi-channel synchronizer plus stability filter for slow asynchronous
//   control/status lines (HPD, lock flags, buttons, straps). Each channel runs
//   through a STAGES-deep flop chain. A new level is accepted only after the
//   synchronized value has differed from the current output for FILTER_CNT
//   consecutive cycles. Every accepted change emits a one-cycle rise or fall
//   pulse.
//
// Ports
//   clk_dst    in   1      destination clock, all logic on its rising edge
//   rst_n      in   1      synchronous active-low reset
//   sig_in     in   WIDTH  asynchronous inputs (each bit independent)
//   sig_out    out  WIDTH  filtered, synchronized level per channel
//   rise_pulse out  WIDTH  1-cycle pulse when sig_out[i] goes 0->1
//   fall_pulse out  WIDTH  1-cycle pulse when sig_out[i] goes 1->0
//   busy       out  1      any channel has a pending, not yet accepted change
module cdc_sync_debounce #(
  parameter int               WIDTH      = 4,
  parameter int               STAGES     = 2,
  parameter int               FILTER_CNT = 16,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic             clk_dst,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sig_in,
  output logic [WIDTH-1:0] sig_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             busy
);

  localparam int CW = (FILTER_CNT > 1) ? $clog2(FILTER_CNT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CNT - 1);

  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync_chain [STAGES];
  logic [WIDTH-1:0] s_p0;
  logic [CW-1:0]    cnt [WIDTH];

  // Synchronized value seen by the filter.
  assign s_p0 = sync_chain[STAGES-1];

  // Pending change = synchronized level disagrees with accepted level.
  assign busy = |(s_p0 ^ sig_out);

  always_ff @(posedge clk_dst) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) sync_chain[k] <= RESET_VAL;
      sig_out    <= RESET_VAL;
      rise_pulse <= '0;
      fall_pulse <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      // Synchronizer chain stage boundary.
      sync_chain[0] <= sig_in;
      for (int k = 1; k < STAGES; k++) sync_chain[k] <= sync_chain[k-1];

      // Filter / acceptance stage boundary.
      rise_pulse <= '0;
      fall_pulse <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (s_p0[i] == sig_out[i]) begin
          // Input returned to the accepted level: abandon the pending change.
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          sig_out[i]    <= s_p0[i];
          rise_pulse[i] <= s_p0[i];
          fall_pulse[i] <= ~s_p0[i];
          cnt[i]        <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_cdc_sync_debounce.sv
module tb_cdc_sync_debounce;

  localparam int W  = 4;
  localparam int ST = 2;
  localparam int FC = 4;
  localparam int MAXE = 4096;

  logic         clk_dst = 1'b0;
  logic         rst_n   = 1'b0;
  logic [W-1:0] sig_in  = '0;
  logic [W-1:0] sig_out, rise_pulse, fall_pulse;
  logic         busy;

  int errors = 0;
  int checks = 0;

  cdc_sync_debounce #(.WIDTH(W), .STAGES(ST), .FILTER_CNT(FC), .RESET_VAL('0)) dut (
    .clk_dst(clk_dst), .rst_n(rst_n), .sig_in(sig_in), .sig_out(sig_out),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .busy(busy)
  );

  always #5 clk_dst = ~clk_dst;

  // Reference model: history of every edge's inputs; outputs are derived from
  // sliding windows over that history rather than from counters.
  logic [W-1:0] in_h [MAXE];
  bit           rst_h [MAXE];
  int           ne = 0;
  logic [W-1:0] m_out = '0, m_rise = '0, m_fall = '0;
  logic         m_busy = 1'b0;

  // Synchronized value present after edge e: input captured STAGES-1 edges
  // earlier, unless a reset hit the chain in between.
  function automatic logic [W-1:0] sval(int e);
    if (e - ST + 1 < 0) return '0;
    for (int k = e - ST + 1; k <= e; k++) if (rst_h[k]) return '0;
    return in_h[e - ST + 1];
  endfunction

  always @(posedge clk_dst) begin
    logic [W-1:0] sv;
    bit ok;
    if (ne < MAXE) begin
      in_h[ne]  = sig_in;
      rst_h[ne] = !rst_n;
      m_rise = '0;
      m_fall = '0;
      if (rst_h[ne]) begin
        m_out = '0;
      end else begin
        for (int ch = 0; ch < W; ch++) begin
          ok = 1;
          for (int j = ne - FC + 1; j <= ne; j++) begin
            if (j < 0 || rst_h[j]) ok = 0;
            else begin
              sv = sval(j - 1);
              if (sv[ch] == m_out[ch]) ok = 0;
            end
          end
          if (ok) begin
            m_out[ch]  = ~m_out[ch];
            m_rise[ch] = m_out[ch];
            m_fall[ch] = ~m_out[ch];
          end
        end
      end
      m_busy = |(sval(ne) ^ m_out);
      ne++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then compare all outputs against the model.
  task automatic tick();
    @(posedge clk_dst);
    #1;
    chk("model_sig_out", 32'(sig_out), 32'(m_out));
    chk("model_rise", 32'(rise_pulse), 32'(m_rise));
    chk("model_fall", 32'(fall_pulse), 32'(m_fall));
    chk("model_busy", 32'(busy), 32'(m_busy));
  endtask

  int nr, nf;

  initial begin
    // Test 1: all-ones held through reset.
    sig_in = 4'hF; rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_reset_out", 32'(sig_out), 32'h0);
      chk("t1_reset_rise", 32'(rise_pulse), 32'h0);
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e < 6) chk("t1_out_early", 32'(sig_out), 32'h0);
      if (e == 6) begin
        chk("t1_out_edge6", 32'(sig_out), 32'hF);
        chk("t1_rise_edge6", 32'(rise_pulse), 32'hF);
      end
      if (e == 7) chk("t1_rise_edge7", 32'(rise_pulse), 32'h0);
    end

    // Test 2: latency and busy window on channel 0.
    rst_n = 1'b0; sig_in = '0;
    repeat (3) tick();
    rst_n = 1'b1; sig_in = 4'b0001;
    for (int e = 1; e <= 7; e++) begin
      tick();
      chk("t2_busy", 32'(busy), (e >= 2 && e <= 5) ? 32'h1 : 32'h0);
      chk("t2_out", 32'(sig_out), (e >= 6) ? 32'h1 : 32'h0);
      chk("t2_rise", 32'(rise_pulse), (e == 6) ? 32'h1 : 32'h0);
    end

    // Test 3: glitch on channel 1, then a long enough pulse.
    nr = 0; nf = 0;
    sig_in[1] = 1'b1;
    repeat (3) begin tick(); nr += rise_pulse[1]; nf += fall_pulse[1]; end
    sig_in[1] = 1'b0;
    repeat (10) begin tick(); nr += rise_pulse[1]; nf += fall_pulse[1]; end
    chk("t3_glitch_rise", 32'(nr), 32'd0);
    chk("t3_glitch_fall", 32'(nf), 32'd0);
    sig_in[1] = 1'b1;
    repeat (12) begin tick(); nr += rise_pulse[1]; end
    chk("t3_accept_rise", 32'(nr), 32'd1);
    chk("t3_accept_out", 32'(sig_out[1]), 32'h1);

    // Test 4: bounce on channel 2, then settle high.
    nr = 0; nf = 0;
    for (int k = 0; k < 10; k++) begin
      sig_in[2] = ~sig_in[2];
      repeat (2) begin tick(); nr += rise_pulse[2]; nf += fall_pulse[2]; end
    end
    sig_in[2] = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      nr += rise_pulse[2]; nf += fall_pulse[2];
      if (e == 6) chk("t4_rise_edge6", 32'(rise_pulse[2]), 32'h1);
    end
    chk("t4_rise_count", 32'(nr), 32'd1);
    chk("t4_fall_count", 32'(nf), 32'd0);

    // Test 5: simultaneous rise and fall on different channels.
    sig_in = 4'b1000;
    repeat (12) tick();
    chk("t5_pre_out", 32'(sig_out), 32'h8);
    sig_in = 4'b0001;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e == 6) begin
        chk("t5_rise", 32'(rise_pulse), 32'h1);
        chk("t5_fall", 32'(fall_pulse), 32'h8);
        chk("t5_out", 32'(sig_out), 32'h1);
      end
    end

    // Test 6: reset while channel 0 is mid-count.
    rst_n = 1'b0; sig_in = '0;
    repeat (2) tick();
    rst_n = 1'b1; sig_in = 4'b0001;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    chk("t6_reset_out", 32'(sig_out), 32'h0);
    chk("t6_reset_rise", 32'(rise_pulse), 32'h0);
    rst_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      chk("t6_out", 32'(sig_out), (e == 6) ? 32'h1 : 32'h0);
      chk("t6_rise", 32'(rise_pulse), (e == 6) ? 32'h1 : 32'h0);
    end

    // Random phase: sparse bit flips with occasional resets.
    for (int c = 0; c < 1500; c++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 10) sig_in[$urandom_range(0, W-1)] ^= 1'b1;
      rst_n = (r == 99) ? 1'b0 : 1'b1;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
